// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader: image geometry, byte width
// and the loader state encoding.
package prog_loader_pkg;

    localparam int DATA_W = 15;
    localparam int ADDR_W = 4;
    localparam int WORDS  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WR,
        CSUM,
        FIN,
        FAIL
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == HI) || (s == LO) || (s == WR) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_ld_csum.sv
// 8-bit wrap-around byte accumulator with synchronous clear and a check that
// the running sum plus a candidate checksum byte is zero modulo 256.
module ld_csum
    import prog_loader_pkg::*;
(
    input  logic              CLK_LD,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] din,
    input  logic [BYTE_W-1:0] chk,
    output logic [BYTE_W-1:0] sum,
    output logic              zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_LD or negedge RESET_N) begin
        if (!RESET_N)    sum <= '0;
        else if (clr)    sum <= '0;
        else if (add_en) sum <= sum + din;
    end

    assign zero = (BYTE_W'(sum + chk) == '0);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: pairs bytes into instruction words, writes them
// sequentially into program memory, then verifies a trailing checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = prog_loader_pkg::DATA_W,
    parameter int ADDR_W = prog_loader_pkg::ADDR_W,
    parameter int WORDS  = prog_loader_pkg::WORDS
) (
    input  logic              CLK_LD,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              CPU_HOLD
);

    localparam int HI_W = DATA_W - BYTE_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [HI_W-1:0]   hi_q, hi_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              done_nxt, err_nxt;
    logic              sum_clr, sum_add, sum_zero;
    logic [BYTE_W-1:0] sum;
    logic              accept;

    assign accept = RX_VALID && RX_READY;

    ld_csum u_csum (
        .CLK_LD  (CLK_LD),
        .RESET_N (RESET_N),
        .clr     (sum_clr),
        .add_en  (sum_add),
        .din     (RX_DATA),
        .chk     (RX_DATA),
        .sum     (sum),
        .zero    (sum_zero)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        hi_nxt    = hi_q;
        waddr_nxt = WADDR;
        wdata_nxt = WDATA;
        done_nxt  = DONE;
        err_nxt   = ERR;
        sum_clr   = 1'b0;
        sum_add   = 1'b0;
        unique case (state)
            IDLE, FIN, FAIL: begin
                if (START) begin
                    state_nxt = HI;
                    addr_nxt  = '0;
                    sum_clr   = 1'b1;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            HI: begin
                if (accept) begin
                    if (RX_DATA[7]) begin
                        state_nxt = FAIL;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        hi_nxt    = RX_DATA[HI_W-1:0];
                        sum_add   = 1'b1;
                        state_nxt = LO;
                    end
                end
            end
            LO: begin
                if (accept) begin
                    wdata_nxt = {hi_q, RX_DATA};
                    waddr_nxt = addr;
                    sum_add   = 1'b1;
                    state_nxt = WR;
                end
            end
            WR: begin
                // The last word goes straight to the checksum, so addr never wraps.
                if (addr == ADDR_W'(WORDS - 1)) begin
                    state_nxt = CSUM;
                end else begin
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = HI;
                end
            end
            CSUM: begin
                if (accept) begin
                    done_nxt  = 1'b1;
                    err_nxt   = !sum_zero;
                    state_nxt = sum_zero ? FIN : FAIL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_LD or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            addr  <= '0;
            hi_q  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            hi_q  <= hi_nxt;
        end
    end

    // Outputs are registered copies decoded from the next state.
    always_ff @(posedge CLK_LD or negedge RESET_N) begin
        if (!RESET_N) begin
            RX_READY <= 1'b0;
            WE       <= 1'b0;
            WADDR    <= '0;
            WDATA    <= '0;
            BUSY     <= 1'b0;
            CPU_HOLD <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            RX_READY <= (state_nxt == HI) || (state_nxt == LO) || (state_nxt == CSUM);
            WE       <= (state_nxt == WR);
            WADDR    <= waddr_nxt;
            WDATA    <= wdata_nxt;
            BUSY     <= is_busy(state_nxt);
            CPU_HOLD <= is_busy(state_nxt);
            DONE     <= done_nxt;
            ERR      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven image loads, hand-written
// corner sequences and randomized images checked against a reference model.
module tb_prog_loader;

    logic        CLK_LD   = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        START    = 1'b0;
    logic [7:0]  RX_DATA  = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic        WE;
    logic [3:0]  WADDR;
    logic [14:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        CPU_HOLD;

    prog_loader dut (
        .CLK_LD   (CLK_LD),
        .RESET_N  (RESET_N),
        .START    (START),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .WE       (WE),
        .WADDR    (WADDR),
        .WDATA    (WDATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .CPU_HOLD (CPU_HOLD)
    );

    always #5 CLK_LD = ~CLK_LD;

    int checks = 0;
    int errors = 0;

    logic [18:0] wq[$];
    logic [18:0] eq[$];
    logic [7:0]  img [0:32];
    bit          exp_err;

    always @(negedge CLK_LD) if (WE === 1'b1) wq.push_back({WADDR, WDATA});

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] cs;
        bit         gap;
        int         n_wr;
        bit         err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK_LD);
        RESET_N  = 1'b0;
        RX_VALID = 1'b0;
        START    = 1'b0;
        @(negedge CLK_LD);
        RESET_N  = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge CLK_LD);
        START = 1'b1;
        @(negedge CLK_LD);
        START = 1'b0;
    endtask

    // Returns just after the accepting edge; gap randomly withholds RX_VALID.
    task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge CLK_LD);
            n++;
            if (gap && ($urandom_range(0, 1) == 1)) begin
                RX_VALID = 1'b0;
            end else begin
                RX_VALID = 1'b1;
                RX_DATA  = b;
                if (RX_READY) begin
                    @(posedge CLK_LD);
                    #1;
                    RX_VALID = 1'b0;
                    ok = 1'b1;
                end
            end
        end
        RX_VALID = 1'b0;
        check("rx_accept", {31'd0, ok}, 32'd1);
    endtask

    // Reference: words are written in order until a high byte with bit 7 set;
    // a complete image passes when all data bytes plus the checksum sum to 0 mod 256.
    task automatic ref_model();
        int  s;
        bit  fmt;
        eq.delete();
        s   = 0;
        fmt = 1'b0;
        for (int w = 0; w < 16; w++) begin
            if (img[2*w][7]) begin
                fmt = 1'b1;
                break;
            end
            s = s + int'(img[2*w]) + int'(img[2*w+1]);
            eq.push_back({4'(w), img[2*w][6:0], img[2*w+1]});
        end
        if (fmt) exp_err = 1'b1;
        else     exp_err = ((s + int'(img[32])) % 256) != 0;
    endtask

    task automatic run_load(input bit gap, input string tag);
        bit ok;
        bit stop;
        int n;
        wq.delete();
        stop = 1'b0;
        pulse_start();
        for (int i = 0; i < 33 && !stop; i++) begin
            send_byte(img[i], gap, ok);
            if (!ok || !BUSY) stop = 1'b1;
        end
        check({tag, "_done"}, {31'd0, DONE}, 32'd1);
        check({tag, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_hold"}, {31'd0, CPU_HOLD}, 32'd0);
        @(negedge CLK_LD);
        check({tag, "_nwr"}, wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, {13'd0, wq[i]}, {13'd0, eq[i]});
    endtask

    initial begin
        bit ok;
        int s;

        tbl[0] = '{hi: 8'h00, lo: 8'h01, cs: 8'hF0, gap: 1'b0, n_wr: 16, err: 1'b0};
        tbl[1] = '{hi: 8'h00, lo: 8'h01, cs: 8'h00, gap: 1'b0, n_wr: 16, err: 1'b1};
        tbl[2] = '{hi: 8'h00, lo: 8'h01, cs: 8'hF0, gap: 1'b1, n_wr: 16, err: 1'b0};
        tbl[3] = '{hi: 8'h12, lo: 8'h34, cs: 8'hA0, gap: 1'b0, n_wr: 16, err: 1'b0};
        tbl[4] = '{hi: 8'h7F, lo: 8'hFF, cs: 8'h20, gap: 1'b1, n_wr: 16, err: 1'b0};
        tbl[5] = '{hi: 8'h80, lo: 8'h00, cs: 8'h00, gap: 1'b0, n_wr: 0,  err: 1'b1};

        #3;
        check("rst_ready", {31'd0, RX_READY}, 32'd0);
        check("rst_we",    {31'd0, WE},       32'd0);
        check("rst_waddr", {28'd0, WADDR},    32'd0);
        check("rst_wdata", {17'd0, WDATA},    32'd0);
        check("rst_busy",  {31'd0, BUSY},     32'd0);
        check("rst_done",  {31'd0, DONE},     32'd0);
        check("rst_err",   {31'd0, ERR},      32'd0);
        check("rst_hold",  {31'd0, CPU_HOLD}, 32'd0);
        @(negedge CLK_LD);
        RESET_N = 1'b1;

        // Bytes offered while idle are never accepted.
        wq.delete();
        RX_DATA  = 8'h48;
        RX_VALID = 1'b1;
        repeat (4) begin
            @(negedge CLK_LD);
            check("idle_ready", {31'd0, RX_READY}, 32'd0);
        end
        RX_VALID = 1'b0;
        check("idle_nwr", wq.size(), 32'd0);

        // Single word, write timing and hold of WADDR/WDATA.
        pulse_start();
        check("start_ready", {31'd0, RX_READY}, 32'd1);
        check("start_busy",  {31'd0, BUSY},     32'd1);
        send_byte(8'h48, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        check("w0_we",    {31'd0, WE},    32'd1);
        check("w0_waddr", {28'd0, WADDR}, 32'd0);
        check("w0_wdata", {17'd0, WDATA}, 32'h4800);
        @(posedge CLK_LD);
        #1;
        check("w0_we_off", {31'd0, WE},       32'd0);
        check("w0_ready",  {31'd0, RX_READY}, 32'd1);
        check("w0_hold_a", {28'd0, WADDR},    32'd0);
        check("w0_hold_d", {17'd0, WDATA},    32'h4800);

        // START during a load must not reset the address.
        pulse_start();
        send_byte(8'h01, 1'b0, ok);
        send_byte(8'h02, 1'b0, ok);
        check("w1_we",    {31'd0, WE},    32'd1);
        check("w1_waddr", {28'd0, WADDR}, 32'd1);
        check("w1_wdata", {17'd0, WDATA}, 32'h0102);

        // Reset while waiting for the low byte.
        @(posedge CLK_LD);
        #1;
        send_byte(8'h11, 1'b0, ok);
        @(negedge CLK_LD);
        RESET_N = 1'b0;
        #1;
        check("midrst_we",    {31'd0, WE},       32'd0);
        check("midrst_busy",  {31'd0, BUSY},     32'd0);
        check("midrst_ready", {31'd0, RX_READY}, 32'd0);
        check("midrst_done",  {31'd0, DONE},     32'd0);
        check("midrst_err",   {31'd0, ERR},      32'd0);
        check("midrst_hold",  {31'd0, CPU_HOLD}, 32'd0);
        @(negedge CLK_LD);
        RESET_N = 1'b1;

        foreach (tbl[k]) begin
            for (int w = 0; w < 16; w++) begin
                img[2*w]   = tbl[k].hi;
                img[2*w+1] = tbl[k].lo;
            end
            img[32] = tbl[k].cs;
            exp_err = tbl[k].err;
            eq.delete();
            for (int w = 0; w < tbl[k].n_wr; w++) eq.push_back({4'(w), tbl[k].hi[6:0], tbl[k].lo});
            run_load(tbl[k].gap, $sformatf("tbl%0d", k));
        end

        // A new START clears the sticky flags left by the failed load.
        pulse_start();
        check("restart_done",  {31'd0, DONE},     32'd0);
        check("restart_err",   {31'd0, ERR},      32'd0);
        check("restart_busy",  {31'd0, BUSY},     32'd1);
        check("restart_ready", {31'd0, RX_READY}, 32'd1);
        do_reset();

        for (int r = 0; r < 10; r++) begin
            s = 0;
            for (int w = 0; w < 16; w++) begin
                img[2*w]   = {($urandom_range(0, 40) == 0), 7'($urandom)};
                img[2*w+1] = 8'($urandom);
                s = s + int'(img[2*w]) + int'(img[2*w+1]);
            end
            if ($urandom_range(0, 1) == 1) img[32] = 8'((256 - (s % 256)) % 256);
            else                           img[32] = 8'($urandom);
            ref_model();
            run_load(1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
